// File: rtl/fgp_tx_sched.sv
// fgp_tx_sched: packet sequencer for the fgp_tx/eth_tx pipeline.
// Walks a full frame chunk by chunk and interleaves single-chunk requests.
// Each packet gets one start pulse and a held offset. A packet ends on
// pkt_done or on a watchdog expiry. The next start then waits out an idle gap.
module fgp_tx_sched #(
    parameter int NUM_CHUNKS     = 150,
    parameter int GAP_CYCLES     = 96,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_req,
    input  logic       chunk_req,
    input  logic [7:0] chunk_offset,
    input  logic       pkt_done,
    output logic       pkt_start,
    output logic [7:0] pkt_offset,
    output logic       busy,
    output logic       frame_done,
    output logic       chunk_ack,
    output logic       err
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [8:0]       NUM_CHUNKS_V = 9'(NUM_CHUNKS);
    localparam logic [7:0]       LAST_IDX     = 8'(NUM_CHUNKS - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD     = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    // The watchdog counts cycles since the pkt_start cycle. The START cycle
    // counts as 0, so the first WAIT_DONE cycle sees 1.
    localparam logic [WD_W-1:0]  WD_LAST      = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE,
        GAP
    } state_t;

    state_t           state, state_d;
    logic             frame_pend, frame_pend_d;
    logic             frame_active, frame_active_d;
    logic [7:0]       frame_idx, frame_idx_d;
    logic             chunk_pend, chunk_pend_d;
    logic [7:0]       chunk_buf, chunk_buf_d;
    logic             cur_chunk, cur_chunk_d;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_d;
    logic [WD_W-1:0]  wd_cnt, wd_cnt_d;
    logic [7:0]       pkt_offset_d;
    logic             pkt_start_d, busy_d, frame_done_d, chunk_ack_d, err_d;
    logic             sel_go, done_now, chunk_valid;

    assign chunk_valid = ({1'b0, chunk_offset} < NUM_CHUNKS_V);

    // Next-state, selection, request capture and registered-output values
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        state_d        = state;
        frame_pend_d   = frame_pend;
        frame_active_d = frame_active;
        frame_idx_d    = frame_idx;
        chunk_pend_d   = chunk_pend;
        chunk_buf_d    = chunk_buf;
        cur_chunk_d    = cur_chunk;
        gap_cnt_d      = gap_cnt;
        wd_cnt_d       = wd_cnt;
        pkt_offset_d   = pkt_offset;
        pkt_start_d    = 1'b0;
        frame_done_d   = 1'b0;
        chunk_ack_d    = 1'b0;
        err_d          = 1'b0;
        sel_go         = 1'b0;
        done_now       = 1'b0;

        case (state)
            IDLE: sel_go = 1'b1;
            START: begin
                state_d  = WAIT_DONE;
                wd_cnt_d = WD_W'(1);
            end
            WAIT_DONE: begin
                wd_cnt_d = wd_cnt + 1'b1;
                if (pkt_done) begin
                    done_now = 1'b1;
                end else if (wd_cnt == WD_LAST) begin
                    done_now = 1'b1;
                    err_d    = 1'b1;
                end
                if (done_now) begin
                    if (cur_chunk) begin
                        chunk_ack_d = 1'b1;
                    end else if (frame_idx == LAST_IDX) begin
                        frame_done_d   = 1'b1;
                        frame_active_d = 1'b0;
                    end
                    if (GAP_CYCLES == 0) begin
                        sel_go = 1'b1;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) sel_go = 1'b1;
                else               gap_cnt_d = gap_cnt - 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Pick the next packet: a pending chunk first, then the active frame,
        // then a new frame. The consumed flag is cleared here so that a new
        // request captured below in the same cycle survives.
        if (sel_go) begin
            state_d = IDLE;
            if (chunk_pend) begin
                state_d      = START;
                pkt_start_d  = 1'b1;
                pkt_offset_d = chunk_buf;
                cur_chunk_d  = 1'b1;
                chunk_pend_d = 1'b0;
            end else if (frame_active_d) begin
                state_d      = START;
                pkt_start_d  = 1'b1;
                pkt_offset_d = frame_idx + 8'd1;
                frame_idx_d  = frame_idx + 8'd1;
                cur_chunk_d  = 1'b0;
            end else if (frame_pend) begin
                state_d        = START;
                pkt_start_d    = 1'b1;
                pkt_offset_d   = 8'd0;
                frame_idx_d    = 8'd0;
                frame_active_d = 1'b1;
                frame_pend_d   = 1'b0;
                cur_chunk_d    = 1'b0;
            end
        end

        // New requests take priority over the clears made above
        if (frame_req) frame_pend_d = 1'b1;
        if (chunk_req) begin
            if (chunk_valid) begin
                chunk_pend_d = 1'b1;
                chunk_buf_d  = chunk_offset;
            end else begin
                err_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE) || frame_pend_d || chunk_pend_d || frame_active_d;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state        <= IDLE;
            frame_pend   <= 1'b0;
            frame_active <= 1'b0;
            frame_idx    <= 8'd0;
            chunk_pend   <= 1'b0;
            chunk_buf    <= 8'd0;
            cur_chunk    <= 1'b0;
            gap_cnt      <= '0;
            wd_cnt       <= '0;
            pkt_start    <= 1'b0;
            pkt_offset   <= 8'd0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            chunk_ack    <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_d;
            frame_pend   <= frame_pend_d;
            frame_active <= frame_active_d;
            frame_idx    <= frame_idx_d;
            chunk_pend   <= chunk_pend_d;
            chunk_buf    <= chunk_buf_d;
            cur_chunk    <= cur_chunk_d;
            gap_cnt      <= gap_cnt_d;
            wd_cnt       <= wd_cnt_d;
            pkt_start    <= pkt_start_d;
            pkt_offset   <= pkt_offset_d;
            busy         <= busy_d;
            frame_done   <= frame_done_d;
            chunk_ack    <= chunk_ack_d;
            err          <= err_d;
        end
    end

endmodule

// File: tb/tb_fgp_tx_sched.sv
// Testbench for fgp_tx_sched.
// Instance a: 4 chunks, 96-cycle gap, 64-cycle watchdog. It covers frame
// walking, gap timing, interleaving, the watchdog and reset mid-packet.
// Instance b: 150 chunks, no gap. It covers the chunk range table and
// back-to-back starts.
module tb_fgp_tx_sched;

    logic clk;
    logic a_rst_n, b_rst_n;

    logic       a_frame_req, a_chunk_req, a_pkt_done;
    logic [7:0] a_chunk_offset;
    logic       a_pkt_start, a_busy, a_frame_done, a_chunk_ack, a_err;
    logic [7:0] a_pkt_offset;

    logic       b_frame_req, b_chunk_req, b_pkt_done;
    logic [7:0] b_chunk_offset;
    logic       b_pkt_start, b_busy, b_frame_done, b_chunk_ack, b_err;
    logic [7:0] b_pkt_offset;

    int checks   = 0;
    int failures = 0;
    int n;
    int activity;

    typedef struct {
        logic [7:0] off;
        logic       exp_err;
    } chunk_vec_t;

    chunk_vec_t vecs[6];

    fgp_tx_sched #(.NUM_CHUNKS(4), .GAP_CYCLES(96), .TIMEOUT_CYCLES(64)) dut_a (
        .clk          (clk),
        .rst_n        (a_rst_n),
        .frame_req    (a_frame_req),
        .chunk_req    (a_chunk_req),
        .chunk_offset (a_chunk_offset),
        .pkt_done     (a_pkt_done),
        .pkt_start    (a_pkt_start),
        .pkt_offset   (a_pkt_offset),
        .busy         (a_busy),
        .frame_done   (a_frame_done),
        .chunk_ack    (a_chunk_ack),
        .err          (a_err)
    );

    fgp_tx_sched #(.NUM_CHUNKS(150), .GAP_CYCLES(0), .TIMEOUT_CYCLES(4096)) dut_b (
        .clk          (clk),
        .rst_n        (b_rst_n),
        .frame_req    (b_frame_req),
        .chunk_req    (b_chunk_req),
        .chunk_offset (b_chunk_offset),
        .pkt_done     (b_pkt_done),
        .pkt_start    (b_pkt_start),
        .pkt_offset   (b_pkt_offset),
        .busy         (b_busy),
        .frame_done   (b_frame_done),
        .chunk_ack    (b_chunk_ack),
        .err          (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic a_wait_start(input int max_ticks, output int cnt);
        cnt = 0;
        while (a_pkt_start !== 1'b1 && cnt < max_ticks) begin
            tick();
            cnt++;
        end
    endtask

    // Called at the negedge where pkt_start is visible. pkt_done is driven
    // 20 cycles after the start. An optional chunk request is injected
    // mid-packet. The gap to the next start is checked when one is expected.
    task automatic a_packet(input logic [7:0] exp_off, input logic exp_chunk, input logic exp_last,
                            input logic expect_next, input logic inj, input logic [7:0] inj_off);
        int cnt;
        check("pkt_offset", a_pkt_offset, exp_off);
        for (int i = 0; i < 20; i++) begin
            a_chunk_req    = inj && (i == 5);
            a_chunk_offset = inj_off;
            tick();
        end
        a_chunk_req = 1'b0;
        check("pkt_offset_stable", a_pkt_offset, exp_off);
        check("pkt_start_single_pulse", a_pkt_start, 1'b0);
        a_pkt_done = 1'b1;
        tick();
        a_pkt_done = 1'b0;
        check("chunk_ack", a_chunk_ack, exp_chunk);
        check("frame_done", a_frame_done, exp_last);
        if (expect_next) begin
            a_wait_start(200, cnt);
            check("gap_done_to_start", cnt, 96);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        vecs[0] = '{off: 8'd7,   exp_err: 1'b0};
        vecs[1] = '{off: 8'd149, exp_err: 1'b0};
        vecs[2] = '{off: 8'd150, exp_err: 1'b1};
        vecs[3] = '{off: 8'd200, exp_err: 1'b1};
        vecs[4] = '{off: 8'd255, exp_err: 1'b1};
        vecs[5] = '{off: 8'd0,   exp_err: 1'b0};

        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_frame_req = 1'b0; a_chunk_req = 1'b0; a_chunk_offset = 8'd0; a_pkt_done = 1'b0;
        b_frame_req = 1'b0; b_chunk_req = 1'b0; b_chunk_offset = 8'd0; b_pkt_done = 1'b0;
        repeat (3) tick();
        check("reset_pkt_start", a_pkt_start, 1'b0);
        check("reset_pkt_offset", a_pkt_offset, 8'd0);
        check("reset_busy", a_busy, 1'b0);
        check("reset_done_ack_err", {a_frame_done, a_chunk_ack, a_err}, 3'b000);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        repeat (2) tick();

        // Full frame on a 4-chunk instance: offsets 0..3, frame_done only on the last
        a_frame_req = 1'b1; tick(); a_frame_req = 1'b0;
        check("frame_busy_after_req", a_busy, 1'b1);
        check("frame_no_start_yet", a_pkt_start, 1'b0);
        a_wait_start(10, n);
        check("frame_first_start_latency", n, 1);
        a_packet(8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        a_packet(8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        a_packet(8'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        a_packet(8'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        repeat (100) tick();
        check("frame_idle_after_gap", a_busy, 1'b0);

        // Chunk 1 requested while frame packet 2 is in flight: 2, chunk 1, then 3
        a_frame_req = 1'b1; tick(); a_frame_req = 1'b0;
        a_wait_start(10, n);
        check("ilv_first_start_latency", n, 1);
        a_packet(8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        a_packet(8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        a_packet(8'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1);
        a_packet(8'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        a_packet(8'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        repeat (100) tick();
        check("ilv_idle_after_gap", a_busy, 1'b0);

        // Watchdog: no pkt_done, err exactly 64 cycles after the start, next offset follows
        a_frame_req = 1'b1; tick(); a_frame_req = 1'b0;
        a_wait_start(10, n);
        check("wd_first_offset", a_pkt_offset, 8'd0);
        repeat (63) tick();
        check("wd_err_not_early", a_err, 1'b0);
        tick();
        check("wd_err_pulse", a_err, 1'b1);
        check("wd_no_frame_done", a_frame_done, 1'b0);
        a_wait_start(200, n);
        check("wd_gap_to_next", n, 96);
        check("wd_next_offset", a_pkt_offset, 8'd1);

        // Reset while in WAIT_DONE: outputs clear at once; a late pkt_done does nothing
        repeat (3) tick();
        #2 a_rst_n = 1'b0;
        #1;
        check("rst_async_busy", a_busy, 1'b0);
        check("rst_async_offset", a_pkt_offset, 8'd0);
        @(negedge clk);
        a_rst_n = 1'b1;
        a_pkt_done = 1'b1; tick(); a_pkt_done = 1'b0;
        activity = 0;
        for (int i = 0; i < 150; i++) begin
            activity += int'(a_pkt_start) + int'(a_frame_done) + int'(a_chunk_ack) + int'(a_err) + int'(a_busy);
            tick();
        end
        check("rst_late_done_ignored", activity, 0);

        // Chunk range table on the 150-chunk, zero-gap instance
        foreach (vecs[k]) begin
            b_chunk_req = 1'b1; b_chunk_offset = vecs[k].off;
            tick();
            b_chunk_req = 1'b0;
            check("tbl_err", b_err, vecs[k].exp_err);
            check("tbl_busy", b_busy, !vecs[k].exp_err);
            tick();
            check("tbl_pkt_start", b_pkt_start, !vecs[k].exp_err);
            if (!vecs[k].exp_err) check("tbl_pkt_offset", b_pkt_offset, vecs[k].off);
            tick();
            b_pkt_done = 1'b1; tick(); b_pkt_done = 1'b0;
            check("tbl_chunk_ack", b_chunk_ack, !vecs[k].exp_err);
            check("tbl_idle_after", b_busy, 1'b0);
            check("tbl_err_cleared", b_err, 1'b0);
        end

        // Simultaneous frame_req + chunk_req: chunk first, then frame; zero gap means start right after done
        b_frame_req = 1'b1; b_chunk_req = 1'b1; b_chunk_offset = 8'd7;
        tick();
        b_frame_req = 1'b0; b_chunk_req = 1'b0;
        check("sim_busy", b_busy, 1'b1);
        tick();
        check("sim_first_start", b_pkt_start, 1'b1);
        check("sim_first_is_chunk", b_pkt_offset, 8'd7);
        tick();
        b_pkt_done = 1'b1; tick(); b_pkt_done = 1'b0;
        check("sim_chunk_ack", b_chunk_ack, 1'b1);
        check("sim_frame_start_next_cycle", b_pkt_start, 1'b1);
        check("sim_frame_offset0", b_pkt_offset, 8'd0);
        tick();
        b_pkt_done = 1'b1; tick(); b_pkt_done = 1'b0;
        check("sim_frame_offset1_start", b_pkt_start, 1'b1);
        check("sim_frame_offset1", b_pkt_offset, 8'd1);
        check("sim_no_frame_done", b_frame_done, 1'b0);
        b_rst_n = 1'b0; tick(); b_rst_n = 1'b1;
        check("sim_reset_busy", b_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
